mem_lsu_stage: RTL



---
 rtl/mem_lsu_pkg.sv | 45 ++++
 rtl/mem_lsu_stage_lane_align.sv | 74 +++++++
 rtl/mem_lsu_stage.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared opcode encodings, exception causes and FSM state for the load/store stage.
// Also holds the access-size classification used by the alignment check.
package mem_lsu_pkg;

    localparam logic [5:0] OP_LB   = 6'b100001;
    localparam logic [5:0] OP_LH   = 6'b101011;
    localparam logic [5:0] OP_LBU  = 6'b101010;
    localparam logic [5:0] OP_LHU  = 6'b101100;
    localparam logic [5:0] OP_LW   = 6'b111101;
    localparam logic [5:0] OP_LL   = 6'b101000;
    localparam logic [5:0] OP_LWC1 = 6'b110101;
    localparam logic [5:0] OP_LWL  = 6'b101101;
    localparam logic [5:0] OP_LWR  = 6'b101110;
    localparam logic [5:0] OP_SB   = 6'b101111;
    localparam logic [5:0] OP_SH   = 6'b110000;
    localparam logic [5:0] OP_SW   = 6'b110001;
    localparam logic [5:0] OP_SC   = 6'b110110;
    localparam logic [5:0] OP_SWL  = 6'b110010;
    localparam logic [5:0] OP_SWR  = 6'b110011;

    localparam logic [1:0] EXC_NONE    = 2'd0;
    localparam logic [1:0] EXC_MIS_LD  = 2'd1;
    localparam logic [1:0] EXC_MIS_ST  = 2'd2;
    localparam logic [1:0] EXC_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RETIRE} lsu_state_e;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_PART} acc_size_e;

    // Unknown codes fall through to word size so they get the word alignment rule.
    function automatic acc_size_e acc_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB:           acc_size = SZ_BYTE;
            OP_LH, OP_LHU, OP_SH:           acc_size = SZ_HALF;
            OP_LWL, OP_LWR, OP_SWL, OP_SWR: acc_size = SZ_PART;
            default:                        acc_size = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [5:0] op, input logic [1:0] off);
        acc_size_e sz;
        sz = acc_size(op);
        misaligned = ((sz == SZ_HALF) && off[0]) || ((sz == SZ_WORD) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_stage_lane_align.sv
// Byte-lane steering: load extract/merge and store byte-enable/data generation; purely combinational.
// No state and no backpressure; partial-word ops on little-endian use the mirrored offset.
module lsu_lane_align
    import mem_lsu_pkg::*;
#(
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic [5:0]  st_op,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_rt,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [5:0]  ld_op,
    input  logic [1:0]  ld_off,
    input  logic [31:0] ld_rdata,
    input  logic [31:0] ld_rt,
    output logic [31:0] ld_result
);

    logic [1:0]  ld_lane, ld_hlane, ld_eo, ld_ieo;
    logic [1:0]  st_lane, st_hlane, st_eo, st_ieo;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_lane   = BIG_ENDIAN ? (2'd3 - ld_off) : ld_off;
        ld_hlane  = BIG_ENDIAN ? (2'd2 - ld_off) : ld_off;
        ld_eo     = BIG_ENDIAN ? ld_off : (2'd3 - ld_off);
        ld_ieo    = 2'd3 - ld_eo;
        ld_byte   = 8'(ld_rdata >> {ld_lane, 3'b000});
        ld_half   = 16'(ld_rdata >> {ld_hlane, 3'b000});
        case (ld_op)
            OP_LB:   ld_result = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_result = {24'h0, ld_byte};
            OP_LH:   ld_result = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_result = {16'h0, ld_half};
            OP_LWL:  ld_result = (ld_rdata << {ld_eo, 3'b000})
                               | (ld_rt & ~(32'hFFFF_FFFF << {ld_eo, 3'b000}));
            OP_LWR:  ld_result = (ld_rdata >> {ld_ieo, 3'b000})
                               | (ld_rt & ~(32'hFFFF_FFFF >> {ld_ieo, 3'b000}));
            default: ld_result = ld_rdata;
        endcase
    end

    always_comb begin
        st_lane  = BIG_ENDIAN ? (2'd3 - st_off) : st_off;
        st_hlane = BIG_ENDIAN ? (2'd2 - st_off) : st_off;
        st_eo    = BIG_ENDIAN ? st_off : (2'd3 - st_off);
        st_ieo   = 2'd3 - st_eo;
        case (st_op)
            OP_SB: begin
                st_be    = 4'b0001 << st_lane;
                st_wdata = {4{st_rt[7:0]}};
            end
            OP_SH: begin
                st_be    = 4'b0011 << st_hlane;
                st_wdata = {2{st_rt[15:0]}};
            end
            OP_SWL: begin
                st_be    = 4'b1111 >> st_eo;
                st_wdata = st_rt >> {st_eo, 3'b000};
            end
            OP_SWR: begin
                st_be    = 4'b1111 << st_ieo;
                st_wdata = st_rt << {st_ieo, 3'b000};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = st_rt;
            end
        endcase
    end

endmodule

// File: rtl/mem_lsu_stage.sv
// Load/store stage between EXE and WB; non-memory ops retire in 1 cycle, memory ops in ack wait + 2.
// Backpressure: stall_out holds EXE from a memory op's first cycle until dm_ack or timeout.
module mem_lsu_stage
    import mem_lsu_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter bit BIG_ENDIAN     = 1'b1,
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit DEBUG_PRINT    = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              in_valid,
    input  logic [31:0]       in_instr,
    input  logic [31:0]       in_pc,
    input  logic [ADDR_W-1:0] in_alu_result,
    input  logic [4:0]        in_write_reg,
    input  logic [31:0]       in_store_data,
    input  logic              in_reg_write,
    input  logic [5:0]        in_alu_ctrl,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    output logic              stall_out,
    output logic              out_valid,
    output logic [4:0]        WriteRegister1_OUT,
    output logic              RegWrite1_OUT,
    output logic [31:0]       WriteData1_OUT,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic              dm_ack,
    input  logic [31:0]       dm_rdata,
    output logic              exc_valid,
    output logic [1:0]        exc_cause
);

    localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    lsu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [5:0]        cap_op_q, cap_op_d;
    logic [1:0]        cap_off_q, cap_off_d;
    logic [31:0]       cap_rt_q, cap_rt_d;
    logic [31:0]       cap_alu_q, cap_alu_d;
    logic [4:0]        cap_wreg_q, cap_wreg_d;
    logic              cap_regw_q, cap_regw_d;
    logic              cap_rd_q, cap_rd_d;
    logic              out_valid_q, out_valid_d;
    logic [4:0]        wb_reg_q, wb_reg_d;
    logic              wb_we_q, wb_we_d;
    logic [31:0]       wb_data_q, wb_data_d;
    logic              exc_valid_q, exc_valid_d;
    logic [1:0]        exc_cause_q, exc_cause_d;
    logic              dm_req_q, dm_req_d;
    logic              dm_we_q, dm_we_d;
    logic [ADDR_W-1:0] dm_addr_q, dm_addr_d;
    logic [3:0]        dm_be_q, dm_be_d;
    logic [31:0]       dm_wdata_q, dm_wdata_d;

    logic        is_mem, mis, timeout_hit;
    logic [1:0]  in_off;
    logic [3:0]  st_be;
    logic [31:0] st_wdata, ld_result;
    logic        unused_dbg;

    assign is_mem      = in_mem_read | in_mem_write;
    assign in_off      = in_alu_result[1:0];
    assign mis         = misaligned(in_alu_ctrl, in_off);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
    assign unused_dbg  = (^{in_instr, in_pc}) ^ DEBUG_PRINT;

    lsu_lane_align #(.BIG_ENDIAN(BIG_ENDIAN)) u_align (
        .st_op     (in_alu_ctrl),
        .st_off    (in_off),
        .st_rt     (in_store_data),
        .st_be     (st_be),
        .st_wdata  (st_wdata),
        .ld_op     (cap_op_q),
        .ld_off    (cap_off_q),
        .ld_rdata  (dm_rdata),
        .ld_rt     (cap_rt_q),
        .ld_result (ld_result)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cap_op_d    = cap_op_q;
        cap_off_d   = cap_off_q;
        cap_rt_d    = cap_rt_q;
        cap_alu_d   = cap_alu_q;
        cap_wreg_d  = cap_wreg_q;
        cap_regw_d  = cap_regw_q;
        cap_rd_d    = cap_rd_q;
        out_valid_d = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_we_d     = 1'b0;
        wb_data_d   = wb_data_q;
        exc_valid_d = 1'b0;
        exc_cause_d = EXC_NONE;
        dm_req_d    = dm_req_q;
        dm_we_d     = dm_we_q;
        dm_addr_d   = dm_addr_q;
        dm_be_d     = dm_be_q;
        dm_wdata_d  = dm_wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && is_mem) begin
                    cap_op_d   = in_alu_ctrl;
                    cap_off_d  = in_off;
                    cap_rt_d   = in_store_data;
                    cap_alu_d  = 32'(in_alu_result);
                    cap_wreg_d = in_write_reg;
                    cap_regw_d = in_reg_write;
                    cap_rd_d   = in_mem_read;
                    cnt_d      = '0;
                    if (mis) begin
                        state_d     = ST_RETIRE;
                        out_valid_d = 1'b1;
                        wb_reg_d    = in_write_reg;
                        wb_data_d   = 32'h0;
                        exc_valid_d = 1'b1;
                        exc_cause_d = in_mem_read ? EXC_MIS_LD : EXC_MIS_ST;
                    end else begin
                        state_d    = ST_WAIT;
                        dm_req_d   = 1'b1;
                        dm_we_d    = in_mem_write;
                        dm_addr_d  = {in_alu_result[ADDR_W-1:2], 2'b00};
                        dm_be_d    = in_mem_write ? st_be : 4'b0000;
                        dm_wdata_d = in_mem_write ? st_wdata : 32'h0;
                    end
                end else if (in_valid) begin
                    out_valid_d = 1'b1;
                    wb_reg_d    = in_write_reg;
                    wb_we_d     = in_reg_write;
                    wb_data_d   = 32'(in_alu_result);
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // An ack in the limit cycle still completes the access normally.
                if (dm_ack || timeout_hit) begin
                    state_d     = ST_RETIRE;
                    cnt_d       = '0;
                    dm_req_d    = 1'b0;
                    dm_we_d     = 1'b0;
                    dm_addr_d   = '0;
                    dm_be_d     = 4'b0000;
                    dm_wdata_d  = 32'h0;
                    out_valid_d = 1'b1;
                    wb_reg_d    = cap_wreg_q;
                    if (dm_ack) begin
                        wb_we_d   = cap_regw_q;
                        wb_data_d = cap_rd_q ? ld_result : cap_alu_q;
                    end else begin
                        wb_data_d   = 32'h0;
                        exc_valid_d = 1'b1;
                        exc_cause_d = EXC_TIMEOUT;
                    end
                end
            end
            default: begin
                // EXE still shows the finished op this cycle; it advances at this edge.
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cap_op_q    <= '0;
            cap_off_q   <= '0;
            cap_rt_q    <= '0;
            cap_alu_q   <= '0;
            cap_wreg_q  <= '0;
            cap_regw_q  <= 1'b0;
            cap_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            wb_reg_q    <= '0;
            wb_we_q     <= 1'b0;
            wb_data_q   <= '0;
            exc_valid_q <= 1'b0;
            exc_cause_q <= EXC_NONE;
            dm_req_q    <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_addr_q   <= '0;
            dm_be_q     <= '0;
            dm_wdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cap_op_q    <= cap_op_d;
            cap_off_q   <= cap_off_d;
            cap_rt_q    <= cap_rt_d;
            cap_alu_q   <= cap_alu_d;
            cap_wreg_q  <= cap_wreg_d;
            cap_regw_q  <= cap_regw_d;
            cap_rd_q    <= cap_rd_d;
            out_valid_q <= out_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_we_q     <= wb_we_d;
            wb_data_q   <= wb_data_d;
            exc_valid_q <= exc_valid_d;
            exc_cause_q <= exc_cause_d;
            dm_req_q    <= dm_req_d;
            dm_we_q     <= dm_we_d;
            dm_addr_q   <= dm_addr_d;
            dm_be_q     <= dm_be_d;
            dm_wdata_q  <= dm_wdata_d;
        end
    end

    assign stall_out          = RESET && (((state_q == ST_IDLE) && in_valid && is_mem) || (state_q == ST_WAIT));
    assign out_valid          = out_valid_q;
    assign WriteRegister1_OUT = wb_reg_q;
    assign RegWrite1_OUT      = wb_we_q;
    assign WriteData1_OUT     = wb_data_q;
    assign exc_valid          = exc_valid_q;
    assign exc_cause          = exc_cause_q;
    assign dm_req             = dm_req_q;
    assign dm_we              = dm_we_q;
    assign dm_addr            = dm_addr_q;
    assign dm_be              = dm_be_q;
    assign dm_wdata           = dm_wdata_q;

endmodule
